// File: rtl/boot_loader_writer.sv
// ---------------------------------------------------------------------------
// boot_loader_writer
//
// Boot-time loader for the 512x32 instruction/data memory. It receives a byte
// stream from the UART receiver, assembles big-endian 32-bit words, writes
// them through the memory write port, and answers with a one-byte ACK (8'h06)
// or NAK (8'h15) to the UART transmitter. The CPU is held in reset while a
// load is in progress.
//
// Frame: CMD_LOAD, N[15:8], N[7:0], 4*N data bytes [, checksum byte]
//
// Configuration macro: LOADER_CHECKSUM_EN
//   defined   - one checksum byte (8-bit sum of all data bytes) follows the
//               data; a match gives ACK and a mismatch gives NAK.
//   undefined - no checksum byte; a legal load always ends with ACK.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   rx_valid   in   1       one-cycle strobe: rx_data holds a received byte
//   rx_data    in   8       received byte
//   tx_valid   out  1       response byte pending
//   tx_data    out  8       response byte (ACK 8'h06 / NAK 8'h15)
//   tx_ready   in   1       transmitter takes tx_data on tx_valid & tx_ready
//   mem_we     out  1       one-cycle memory write strobe
//   mem_addr   out  ADDR_W  memory write word address
//   mem_wdata  out  32      memory write data
//   cpu_hold   out  1       high while a load is in progress
//   done       out  1       one-cycle pulse when an ACK is accepted
// ---------------------------------------------------------------------------
module boot_loader_writer #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [7:0]  CMD_LOAD  = 8'h4C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done
);

    localparam logic [7:0]        ACK   = 8'h06;
    localparam logic [7:0]        NAK   = 8'h15;
    localparam logic [16:0]       DEPTH = 17'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_RESP
    } state_t;

    state_t            state_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       rem_q;      // words still to be received
    logic [1:0]        byte_cnt_q; // byte position inside the current word
    logic [23:0]       shift_q;    // first three bytes of the current word
    logic [7:0]        csum_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;

    // Values formed from the byte arriving this cycle.
    logic [15:0] len_d;
    logic [31:0] word_d;
    logic [7:0]  csum_d;
    logic        len_bad_d;

    assign len_d     = {len_hi_q, rx_data};
    assign word_d    = {shift_q, rx_data};
    assign csum_d    = csum_q + rx_data;
    assign len_bad_d = {1'b0, len_d} > DEPTH;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= 8'h00;
            rem_q       <= 16'h0000;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'h000000;
            csum_q      <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= 32'h0000_0000;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            // The address advances in the cycle the write is presented, so
            // word k lands at BASE+k; the ADDR_W-bit counter wraps naturally.
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == CMD_LOAD) begin
                        state_q    <= ST_LEN_HI;
                        cpu_hold_q <= 1'b1;
                        mem_addr_q <= BASE;
                        csum_q     <= 8'h00;
                        byte_cnt_q <= 2'd0;
                    end
                end

                ST_LEN_HI: begin
                    if (rx_valid) begin
                        len_hi_q <= rx_data;
                        state_q  <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (rx_valid) begin
                        if (len_bad_d) begin
                            state_q    <= ST_RESP;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= NAK;
                        end else if (len_d == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= ST_CSUM;
`else
                            state_q    <= ST_RESP;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= ACK;
`endif
                        end else begin
                            rem_q   <= len_d;
                            state_q <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        csum_q     <= csum_d;
                        shift_q    <= {shift_q[15:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= word_d;
                            rem_q       <= rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q    <= ST_CSUM;
`else
                                state_q    <= ST_RESP;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= ACK;
`endif
                            end
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        state_q    <= ST_RESP;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= (rx_data == csum_q) ? ACK : NAK;
                    end
                end
`endif

                // Received bytes are dropped here, including one arriving in
                // the same cycle as the handshake.
                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= (tx_data_q == ACK);
                        cpu_hold_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;

endmodule

// File: tb/tb_boot_loader_writer.sv
// ---------------------------------------------------------------------------
// tb_boot_loader_writer
//
// Directed bench for boot_loader_writer. Stimulus pushes the expected memory
// writes and response bytes into queues; an independent monitor pops and
// compares them whenever the DUT presents a write or a response handshake.
// ---------------------------------------------------------------------------
module tb_boot_loader_writer;

    localparam int         ADDR_W = 9;
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [7:0] CMD    = 8'h4C;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;

    boot_loader_writer #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0),
        .CMD_LOAD (CMD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rsp[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       prev_we, prev_txv, prev_hs, done_exp;
    logic [7:0] prev_txd;

    initial begin
        wr_t        e;
        logic [7:0] r;
        prev_we  = 1'b0;
        prev_txv = 1'b0;
        prev_hs  = 1'b0;
        prev_txd = 8'h00;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we  = 1'b0;
                prev_txv = 1'b0;
                prev_hs  = 1'b0;
                done_exp = 1'b0;
            end else begin
                if (done || done_exp) check("done_pulse", 32'(done), 32'(done_exp));
                done_exp = 1'b0;

                if (mem_we) begin
                    check("we_spacing", 32'(prev_we), 32'd0);
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0d data %08h, expected no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e.addr));
                        check("wr_data", mem_wdata, e.data);
                    end
                end

                // A pending response must hold until it is accepted.
                if (prev_txv && !prev_hs) begin
                    check("tx_valid_hold", 32'(tx_valid), 32'd1);
                    check("tx_data_hold", 32'(tx_data), 32'(prev_txd));
                end

                if (tx_valid && tx_ready) begin
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got %02h, expected none", tx_data);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("resp_byte", 32'(tx_data), 32'(r));
                        done_exp = (r == ACK);
                    end
                end

                prev_we  = mem_we;
                prev_txv = tx_valid;
                prev_txd = tx_data;
                prev_hs  = tx_valid && tx_ready;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends one complete load frame; expectations are queued before the byte
    // that triggers them.
    task automatic run_load(input logic [15:0] n, input logic [7:0] bytes[$], input bit bad_csum);
        logic [7:0]  csum;
        logic [31:0] word;
        int          nbytes;
        csum   = 8'h00;
        word   = 32'h0;
        nbytes = 4 * int'(n);
        send(CMD);
        send(n[15:8]);
        if (int'(n) > DEPTH) begin
            exp_rsp.push_back(NAK);
            send(n[7:0]);
            check("cpu_hold_busy", 32'(cpu_hold), 32'd1);
            return;
        end
`ifndef LOADER_CHECKSUM_EN
        if (n == 16'h0000) exp_rsp.push_back(ACK);
`endif
        send(n[7:0]);
        check("cpu_hold_busy", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < nbytes; i++) begin
            csum = csum + bytes[i];
            word = {word[23:0], bytes[i]};
            if (i % 4 == 3) begin
                exp_wr.push_back('{addr: ADDR_W'(i / 4), data: word});
`ifndef LOADER_CHECKSUM_EN
                if (i == nbytes - 1) exp_rsp.push_back(ACK);
`endif
            end
            send(bytes[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        exp_rsp.push_back(bad_csum ? NAK : ACK);
        send(bad_csum ? csum + 8'h01 : csum);
`else
        if (bad_csum) $display("note: checksum disabled in this build");
`endif
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check({name, "_drained"}, 32'(exp_rsp.size() + exp_wr.size()), 32'd0);
        tick();
        tick();
        check({name, "_hold_released"}, 32'(cpu_hold), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [7:0] q1[$];
        logic [7:0] q2[$];
        logic [7:0] big[$];
        logic [7:0] none[$];

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Idle noise: nothing but CMD_LOAD may start a load.
        foreach (q2[i]) q2.delete(i);
        q2 = '{8'h00, 8'hFF, 8'h06, 8'h15, 8'h4B, 8'h4D, 8'hCC};
        foreach (q2[i]) send(q2[i]);
        tick();
        check("noise_cpu_hold", 32'(cpu_hold), 32'd0);

        // Test 1: two words, ACK.
        q1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_load(16'd2, q1, 1'b0);
        wait_done("t1");

`ifdef LOADER_CHECKSUM_EN
        // Test 2: checksum mismatch; writes still happen, NAK, no done.
        run_load(16'd2, q1, 1'b1);
        wait_done("t2");
`endif

        // Test 3: N = 513 is rejected without any write.
        run_load(16'd513, none, 1'b0);
        wait_done("t3");
        send(8'h00);  // bytes after a NAK are ignored until CMD_LOAD
        send(8'h02);
        tick();
        check("t3_resync_idle", 32'(cpu_hold), 32'd0);

        // Zero-length load.
        run_load(16'd0, none, 1'b0);
        wait_done("t_zero");

        // Test 4: full depth; last write at the top address, then wrap.
        for (int i = 0; i < 4 * DEPTH; i++) big.push_back(8'((i * 37 + 11) & 255));
        run_load(16'(DEPTH), big, 1'b0);
        wait_done("t4");
        check("t4_addr_wrap", 32'(mem_addr), 32'd0);

        // Test 5: transmitter stalls while bytes keep arriving.
        q2 = '{8'h10, 8'h20, 8'h30, 8'h40};
        tx_ready = 1'b0;
        run_load(16'd1, q2, 1'b0);
        for (int i = 0; i < 10; i++) send((i % 2 == 0) ? CMD : 8'h00);
        check("t5_resp_pending", 32'(tx_valid), 32'd1);
        check("t5_cpu_hold", 32'(cpu_hold), 32'd1);
        tx_ready = 1'b1;
        send(CMD);  // arrives in the handshake cycle and must be dropped
        wait_done("t5");

        // Test 6: reset after six data bytes.
        send(CMD);
        send(8'h00);
        send(8'h02);
        exp_wr.push_back('{addr: ADDR_W'(0), data: 32'hCAFE_F00D});
        q2 = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h55, 8'h66};
        foreach (q2[i]) send(q2[i]);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t6_tx_valid", 32'(tx_valid), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        repeat (5) tick();
        check("t6_no_resp", 32'(tx_valid), 32'd0);
        check("t6_one_write", 32'(exp_wr.size()), 32'd0);

        // A full load after the abort completes normally.
        q1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hFF, 8'h00};
        run_load(16'd2, q1, 1'b0);
        wait_done("t6_reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
